// File: rtl/gb_cpu_interrupt_ctrl_if.sv
// Bus, command and dispatch signals between the CPU core and the interrupt controller.
interface gb_cpu_interrupt_ctrl_if;
    logic [4:0]  irq_in;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_wren;
    logic [7:0]  bus_rdata;
    logic        bus_rd_hit;
    logic        instr_boundary;
    logic        ei_cmd;
    logic        di_cmd;
    logic        reti_cmd;
    logic        halt_cmd;
    logic        ime;
    logic        halted;
    logic        halt_bug;
    logic        dispatch_active;
    logic [2:0]  dispatch_step;
    logic        write_interrupt_vector;
    logic [7:0]  interrupt_vector;

    modport master (
        output irq_in, bus_addr, bus_wdata, bus_wren,
        output instr_boundary, ei_cmd, di_cmd, reti_cmd, halt_cmd,
        input  bus_rdata, bus_rd_hit, ime, halted, halt_bug,
        input  dispatch_active, dispatch_step, write_interrupt_vector, interrupt_vector
    );

    modport slave (
        input  irq_in, bus_addr, bus_wdata, bus_wren,
        input  instr_boundary, ei_cmd, di_cmd, reti_cmd, halt_cmd,
        output bus_rdata, bus_rd_hit, ime, halted, halt_bug,
        output dispatch_active, dispatch_step, write_interrupt_vector, interrupt_vector
    );
endinterface

// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy interrupt controller: IE/IF registers, IME with EI delay, HALT/wake
// handling and the multi-cycle dispatch sequencer feeding the register file.
module gb_cpu_interrupt_ctrl #(
    parameter int unsigned DISPATCH_CYCLES = 5,
    parameter logic [7:0]  VECTOR_BASE     = 8'h40
) (
    input  logic                     clk,
    input  logic                     reset,
    gb_cpu_interrupt_ctrl_if.slave   irq_bus
);
    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_DISPATCH} state_e;

    localparam logic [2:0] LAST_STEP    = 3'(DISPATCH_CYCLES - 1);
    localparam logic [2:0] RESOLVE_STEP = 3'(DISPATCH_CYCLES - 2);

    state_e     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [7:0] ie_q, ie_d;
    logic [4:0] if_q, if_d;
    logic       ime_q, ime_d;
    logic       ei_q, ei_d;
    logic [7:0] vec_q, vec_d;
    logic       halt_bug_q, halt_bug_d;

    logic       hit_ie, hit_if;
    logic [4:0] pending, if_clear;
    logic       ime_eff, sel_valid;
    logic [2:0] sel_idx;

    assign hit_ie  = irq_bus.bus_addr == 16'hFFFF;
    assign hit_if  = irq_bus.bus_addr == 16'hFF0F;
    assign pending = ie_q[4:0] & if_q[4:0];
    assign ime_eff = (ime_q | ei_q | irq_bus.reti_cmd) & ~irq_bus.di_cmd;

    assign irq_bus.bus_rd_hit = hit_ie | hit_if;
    assign irq_bus.bus_rdata  = hit_if ? {3'b111, if_q} : (hit_ie ? ie_q : 8'h00);
    assign irq_bus.ime                    = ime_q;
    assign irq_bus.halted                 = state_q == ST_HALT;
    assign irq_bus.halt_bug               = halt_bug_q;
    assign irq_bus.dispatch_active        = state_q == ST_DISPATCH;
    assign irq_bus.dispatch_step          = step_q;
    assign irq_bus.write_interrupt_vector = (state_q == ST_DISPATCH) && (step_q == LAST_STEP);
    assign irq_bus.interrupt_vector       = vec_q;

    // Lowest pending bit has highest priority.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (pending[i] && !sel_valid) begin
                sel_valid = 1'b1;
                sel_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        vec_d      = vec_q;
        ime_d      = ime_q;
        ei_d       = ei_q;
        halt_bug_d = 1'b0;
        if_clear   = '0;

        case (state_q)
            ST_RUN: begin
                if (irq_bus.instr_boundary) begin
                    if (ei_q) begin
                        ime_d = 1'b1;
                        ei_d  = 1'b0;
                    end
                    if (irq_bus.ei_cmd)   ei_d  = 1'b1;
                    if (irq_bus.reti_cmd) ime_d = 1'b1;
                end
                if (irq_bus.di_cmd) begin
                    ime_d = 1'b0;
                    ei_d  = 1'b0;
                end
                // Dispatch entry overrides every IME update made above.
                if (irq_bus.instr_boundary && ime_eff && (pending != '0)) begin
                    state_d = ST_DISPATCH;
                    step_d  = '0;
                    ime_d   = 1'b0;
                    ei_d    = 1'b0;
                end else if (irq_bus.instr_boundary && irq_bus.halt_cmd) begin
                    if (!ime_q && (pending != '0)) halt_bug_d = 1'b1;
                    else                           state_d    = ST_HALT;
                end
            end
            ST_HALT: begin
                if (pending != '0) begin
                    if (ime_q) begin
                        state_d = ST_DISPATCH;
                        step_d  = '0;
                        ime_d   = 1'b0;
                        ei_d    = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DISPATCH: begin
                if (step_q == RESOLVE_STEP) begin
                    if (sel_valid) begin
                        vec_d    = VECTOR_BASE + {2'b00, sel_idx, 3'b000};
                        if_clear = 5'(1) << sel_idx;
                    end else begin
                        vec_d = 8'h00;
                    end
                end
                if (step_q == LAST_STEP) begin
                    state_d = ST_RUN;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        ie_d = (irq_bus.bus_wren && hit_ie) ? irq_bus.bus_wdata : ie_q;
        if_d = (((irq_bus.bus_wren && hit_if) ? irq_bus.bus_wdata[4:0] : if_q) & ~if_clear)
               | irq_bus.irq_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            step_q     <= '0;
            ie_q       <= '0;
            if_q       <= 5'h01;
            ime_q      <= 1'b0;
            ei_q       <= 1'b0;
            vec_q      <= '0;
            halt_bug_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            ie_q       <= ie_d;
            if_q       <= if_d;
            ime_q      <= ime_d;
            ei_q       <= ei_d;
            vec_q      <= vec_d;
            halt_bug_q <= halt_bug_d;
        end
    end
endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Self-checking bench for gb_cpu_interrupt_ctrl: vector table, random register
// traffic and priority against a reference model, plus dispatch/HALT corner sequences.
module tb_gb_cpu_interrupt_ctrl;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    gb_cpu_interrupt_ctrl_if bus();

    gb_cpu_interrupt_ctrl #(.DISPATCH_CYCLES(5), .VECTOR_BASE(8'h40)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ie;
        logic [4:0] ifv;
        logic [7:0] vec;
        logic [7:0] if_rd;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.irq_in = '0; bus.bus_addr = '0; bus.bus_wdata = '0; bus.bus_wren = 1'b0;
        bus.instr_boundary = 1'b0; bus.ei_cmd = 1'b0; bus.di_cmd = 1'b0;
        bus.reti_cmd = 1'b0; bus.halt_cmd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.bus_addr = a; bus.bus_wdata = d; bus.bus_wren = 1'b1;
        tick();
        bus.bus_wren = 1'b0; bus.bus_addr = '0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        bus.bus_addr = a;
        #1;
        d = bus.bus_rdata;
        bus.bus_addr = '0;
    endtask

    task automatic boundary(input logic ei, input logic reti, input logic halt);
        bus.instr_boundary = 1'b1; bus.ei_cmd = ei; bus.reti_cmd = reti; bus.halt_cmd = halt;
        tick();
        clr_inputs();
    endtask

    // Called in step 0 of a dispatch; walks to RUN checking step and vector pulse.
    task automatic follow_dispatch(input string tag, input logic [7:0] exp_vec);
        check({tag, ".active0"}, 32'(bus.dispatch_active), 32'd1);
        check({tag, ".step0"}, 32'(bus.dispatch_step), 32'd0);
        for (int s = 1; s <= 4; s++) begin
            tick();
            check({tag, ".step"}, 32'(bus.dispatch_step), 32'(s));
            check({tag, ".wiv"}, 32'(bus.write_interrupt_vector), 32'(s == 4));
        end
        check({tag, ".vector"}, 32'(bus.interrupt_vector), 32'(exp_vec));
        tick();
        check({tag, ".done"}, 32'(bus.dispatch_active), 32'd0);
        check({tag, ".wiv_off"}, 32'(bus.write_interrupt_vector), 32'd0);
        check({tag, ".ime"}, 32'(bus.ime), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] ie_m;
        logic [4:0] if_m;
        logic [4:0] irqv;
        logic [4:0] pend;
        logic [15:0] a;
        int n;

        n_cmp = 0;
        n_err = 0;
        tbl[0] = '{8'h01, 5'h01, 8'h40, 8'hE0};
        tbl[1] = '{8'h1F, 5'h14, 8'h50, 8'hF0};
        tbl[2] = '{8'h1F, 5'h1F, 8'h40, 8'hFE};
        tbl[3] = '{8'h18, 5'h1F, 8'h58, 8'hF7};
        tbl[4] = '{8'h10, 5'h10, 8'h60, 8'hE0};
        tbl[5] = '{8'h06, 5'h1C, 8'h50, 8'hF8};
        tbl[6] = '{8'h02, 5'h03, 8'h48, 8'hE1};

        clr_inputs();
        do_reset();

        rd(16'hFFFF, d); check("rst.ie", 32'(d), 32'h00);
        rd(16'hFF0F, d); check("rst.if", 32'(d), 32'hE1);
        check("rst.ime", 32'(bus.ime), 32'd0);
        check("rst.halted", 32'(bus.halted), 32'd0);
        check("rst.active", 32'(bus.dispatch_active), 32'd0);
        check("rst.step", 32'(bus.dispatch_step), 32'd0);
        check("rst.vec", 32'(bus.interrupt_vector), 32'h00);
        check("rst.wiv", 32'(bus.write_interrupt_vector), 32'd0);
        check("rst.hbug", 32'(bus.halt_bug), 32'd0);

        // Table-driven vectors, entered via RETI for immediate dispatch.
        for (int i = 0; i < 7; i++) begin
            wr(16'hFFFF, tbl[i].ie);
            wr(16'hFF0F, {3'b000, tbl[i].ifv});
            boundary(1'b0, 1'b1, 1'b0);
            follow_dispatch($sformatf("tbl%0d", i), tbl[i].vec);
            rd(16'hFF0F, d); check($sformatf("tbl%0d.if", i), 32'(d), 32'(tbl[i].if_rd));
        end

        // Random register traffic (IME=0, no boundaries) against register model.
        do_reset();
        ie_m = 8'h00;
        if_m = 5'h01;
        for (int i = 0; i < 120; i++) begin
            d    = 8'($urandom);
            irqv = 5'($urandom);
            case ($urandom_range(0, 3))
                0: begin wr(16'hFFFF, d); ie_m = d; end
                1: begin wr(16'hFF0F, d); if_m = d[4:0]; end
                2: begin bus.irq_in = irqv; tick(); bus.irq_in = '0; if_m = if_m | irqv; end
                default: begin
                    bus.irq_in = irqv;
                    wr(16'hFF0F, d);
                    bus.irq_in = '0;
                    if_m = d[4:0] | irqv;
                end
            endcase
            rd(16'hFFFF, d); check("rnd.ie", 32'(d), 32'(ie_m));
            rd(16'hFF0F, d); check("rnd.if", 32'(d), 32'({3'b111, if_m}));
            a = ($urandom_range(0, 2) == 0) ? 16'hFF0F : 16'($urandom);
            bus.bus_addr = a;
            #1;
            check("rnd.hit", 32'(bus.bus_rd_hit), 32'((a == 16'hFF0F) || (a == 16'hFFFF)));
            bus.bus_addr = '0;
        end

        // Random priority resolution against lowest-set-bit model.
        for (int i = 0; i < 20; i++) begin
            ie_m = 8'($urandom);
            if_m = 5'($urandom);
            pend = ie_m[4:0] & if_m;
            if (pend == '0) begin
                ie_m = ie_m | 8'h01;
                if_m = if_m | 5'h01;
                pend = ie_m[4:0] & if_m;
            end
            n = 0;
            for (int k = 4; k >= 0; k--) if (pend[k]) n = k;
            wr(16'hFFFF, ie_m);
            wr(16'hFF0F, {3'b000, if_m});
            boundary(1'b0, 1'b1, 1'b0);
            follow_dispatch("prio", 8'h40 + 8'(8 * n));
            if_m[n] = 1'b0;
            rd(16'hFF0F, d); check("prio.if", 32'(d), 32'({3'b111, if_m}));
        end

        // EI delay: no dispatch at the EI boundary, dispatch at the next one.
        do_reset();
        wr(16'hFFFF, 8'h01);
        boundary(1'b1, 1'b0, 1'b0);
        check("ei.nodisp", 32'(bus.dispatch_active), 32'd0);
        check("ei.ime0", 32'(bus.ime), 32'd0);
        boundary(1'b0, 1'b0, 1'b0);
        follow_dispatch("ei", 8'h40);
        // DI between the two boundaries suppresses dispatch.
        wr(16'hFF0F, 8'h01);
        boundary(1'b1, 1'b0, 1'b0);
        bus.di_cmd = 1'b1; tick(); clr_inputs();
        boundary(1'b0, 1'b0, 1'b0);
        check("di.nodisp", 32'(bus.dispatch_active), 32'd0);
        check("di.ime", 32'(bus.ime), 32'd0);
        // EI with nothing pending sets IME; then a boundary with IE=01 dispatches.
        wr(16'hFFFF, 8'h00);
        boundary(1'b1, 1'b0, 1'b0);
        boundary(1'b0, 1'b0, 1'b0);
        check("ei.ime1", 32'(bus.ime), 32'd1);
        wr(16'hFFFF, 8'h01);
        check("ime.nobnd", 32'(bus.dispatch_active), 32'd0);
        boundary(1'b0, 1'b0, 1'b0);
        follow_dispatch("ime", 8'h40);
        rd(16'hFF0F, d); check("ime.if", 32'(d), 32'hE0);

        // HALT with IME=0 wakes without dispatch.
        do_reset();
        wr(16'hFF0F, 8'h00);
        wr(16'hFFFF, 8'h04);
        boundary(1'b0, 1'b0, 1'b1);
        check("halt.enter", 32'(bus.halted), 32'd1);
        tick(); tick();
        check("halt.stay", 32'(bus.halted), 32'd1);
        bus.irq_in = 5'h04; tick(); bus.irq_in = '0;
        check("halt.lag", 32'(bus.halted), 32'd1);
        tick();
        check("halt.wake", 32'(bus.halted), 32'd0);
        check("halt.nodisp", 32'(bus.dispatch_active), 32'd0);
        check("halt.nowiv", 32'(bus.write_interrupt_vector), 32'd0);
        // HALT bug: IME=0 and pending.
        boundary(1'b0, 1'b0, 1'b1);
        check("hbug.pulse", 32'(bus.halt_bug), 32'd1);
        check("hbug.nohalt", 32'(bus.halted), 32'd0);
        tick();
        check("hbug.once", 32'(bus.halt_bug), 32'd0);
        check("hbug.run", 32'(bus.halted), 32'd0);
        // HALT with IME=1 wakes into dispatch.
        wr(16'hFF0F, 8'h00);
        boundary(1'b1, 1'b0, 1'b0);
        boundary(1'b0, 1'b0, 1'b0);
        boundary(1'b0, 1'b0, 1'b1);
        check("halt1.enter", 32'(bus.halted), 32'd1);
        bus.irq_in = 5'h04; tick(); bus.irq_in = '0;
        tick();
        check("halt1.wake", 32'(bus.halted), 32'd0);
        follow_dispatch("halt1", 8'h50);

        // IE cleared during the PC_hi push cancels the vector.
        do_reset();
        wr(16'hFFFF, 8'h01);
        boundary(1'b0, 1'b1, 1'b0);
        follow_dispatch("pre", 8'h40);
        wr(16'hFF0F, 8'h01);
        boundary(1'b0, 1'b1, 1'b0);
        tick(); tick();
        check("cancel.step2", 32'(bus.dispatch_step), 32'd2);
        wr(16'hFFFF, 8'h00);
        tick();
        check("cancel.wiv", 32'(bus.write_interrupt_vector), 32'd1);
        check("cancel.vec", 32'(bus.interrupt_vector), 32'h00);
        rd(16'hFF0F, d); check("cancel.if", 32'(d), 32'hE1);
        tick();

        // irq set beats the resolution clear in the same cycle.
        wr(16'hFFFF, 8'h01);
        boundary(1'b0, 1'b1, 1'b0);
        tick(); tick(); tick();
        bus.irq_in = 5'h01; tick(); bus.irq_in = '0;
        check("race.wiv", 32'(bus.write_interrupt_vector), 32'd1);
        check("race.vec", 32'(bus.interrupt_vector), 32'h40);
        rd(16'hFF0F, d); check("race.if", 32'(d), 32'hE1);
        tick();

        // Reset mid-dispatch aborts with no vector pulse.
        wr(16'hFFFF, 8'h01);
        boundary(1'b0, 1'b1, 1'b0);
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("rmid.active", 32'(bus.dispatch_active), 32'd0);
        check("rmid.step", 32'(bus.dispatch_step), 32'd0);
        rd(16'hFFFF, d); check("rmid.ie", 32'(d), 32'h00);
        rd(16'hFF0F, d); check("rmid.if", 32'(d), 32'hE1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rmid.nowiv", 32'(bus.write_interrupt_vector), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
